// File: rtl/serial_word_deserializer_pkg.sv
// Shared types for the stereo serial front end.
// Holds the deserializer state encoding and the sample word type.
package msdap_pkg;
   typedef enum logic {IDLE, SHIFT} deser_state_t;
   localparam int SAMPLE_W = 16;
   typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial-in / parallel-out bundle for serial_word_deserializer.
// frame_err and err_count exist only with DESER_FRAME_ERR_EN.
interface serial_word_deserializer_if
   import msdap_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
);
   logic             enable;
   logic             Frame;
   logic             InputL;
   logic             InputR;
   logic [WIDTH-1:0] dataL;
   logic [WIDTH-1:0] dataR;
   logic             data_valid;
   logic             busy;
`ifdef DESER_FRAME_ERR_EN
   logic             frame_err;
   logic [7:0]       err_count;
`endif

   modport master (
      output enable, Frame, InputL, InputR,
`ifdef DESER_FRAME_ERR_EN
      input  frame_err, err_count,
`endif
      input  dataL, dataR, data_valid, busy
   );

   modport slave (
      input  enable, Frame, InputL, InputR,
`ifdef DESER_FRAME_ERR_EN
      output frame_err, err_count,
`endif
      output dataL, dataR, data_valid, busy
   );
endinterface

// File: rtl/serial_word_deserializer_shift_reg.sv
// Per-channel MSB-first shift register.
// load_msb restarts the word with din as its first bit.
module serial_shift_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_msb,
   input  logic             shift,
   input  logic             din,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load_msb) begin
         q <= {{(WIDTH-1){1'b0}}, din};
      end else if (shift) begin
         q <= {q[WIDTH-2:0], din};
      end
   end
endmodule

// File: rtl/serial_word_deserializer.sv
// Stereo serial-to-parallel word assembler framed by Frame.
// Optional macro DESER_FRAME_ERR_EN adds frame_err / err_count.
module serial_word_deserializer
   import msdap_pkg::*;
#(
   parameter  int WIDTH = SAMPLE_W,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input logic clk,
   input logic rst_n,
   serial_word_deserializer_if.slave bus
);
   deser_state_t     state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             load;
   logic             shift;
   logic             done;
   logic             abort;
   logic [WIDTH-1:0] q_l;
   logic [WIDTH-1:0] q_r;
   logic             unused_msb;

   serial_shift_reg #(.WIDTH(WIDTH)) u_left (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_msb (load),
      .shift    (shift),
      .din      (bus.InputL),
      .q        (q_l)
   );

   serial_shift_reg #(.WIDTH(WIDTH)) u_right (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_msb (load),
      .shift    (shift),
      .din      (bus.InputR),
      .q        (q_r)
   );

   // the final bit bypasses the registers straight into dataL/dataR
   assign unused_msb = q_l[WIDTH-1] ^ q_r[WIDTH-1];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      shift   = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.enable && bus.Frame) begin
               load    = 1'b1;
               cnt_n   = CNT_W'(1);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (!bus.enable) begin
               abort   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (bus.Frame) begin
               abort   = 1'b1;
               load    = 1'b1;
               cnt_n   = CNT_W'(1);
            end else if (cnt == CNT_W'(WIDTH-1)) begin
               done    = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               shift   = 1'b1;
               cnt_n   = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.busy       <= 1'b0;
         bus.data_valid <= 1'b0;
         bus.dataL      <= '0;
         bus.dataR      <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         bus.busy       <= (state_n == SHIFT);
         bus.data_valid <= done;
         if (done) begin
            bus.dataL <= {q_l[WIDTH-2:0], bus.InputL};
            bus.dataR <= {q_r[WIDTH-2:0], bus.InputR};
         end
      end
   end

`ifdef DESER_FRAME_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.frame_err <= 1'b0;
         bus.err_count <= '0;
      end else begin
         bus.frame_err <= abort;
         if (abort && bus.err_count != 8'hFF) begin
            bus.err_count <= bus.err_count + 8'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Randomized bench for serial_word_deserializer with a queue-based model.
// Optional DESER_FRAME_ERR_EN outputs are checked when the macro is set.
module tb_serial_word_deserializer;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_word_deserializer_if #(.WIDTH(W)) bus ();

   serial_word_deserializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int dv_seen = 0;
   int last_dv_cyc = -1;
   int last_fe_cyc = -1;

   bit            m_active;
   bit            ql[$];
   bit            qr[$];
   logic [W-1:0]  exp_l, exp_r;
   logic          exp_dv, exp_busy, exp_fe;
   int            exp_ec;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input bit q[$]);
      logic [W-1:0] v = '0;
      foreach (q[i]) v = W'(v * 2 + W'(q[i]));
      return v;
   endfunction

   task model_reset();
      m_active = 0;
      ql.delete();
      qr.delete();
      exp_l = '0;
      exp_r = '0;
      exp_dv = 0;
      exp_busy = 0;
      exp_fe = 0;
      exp_ec = 0;
   endtask

   task model_err();
      exp_fe = 1;
      if (exp_ec < 255) exp_ec++;
   endtask

   task model_step(input logic en, input logic fr,
                   input logic l, input logic r);
      exp_dv = 0;
      exp_fe = 0;
      if (!m_active) begin
         if (en && fr) begin
            ql = '{l};
            qr = '{r};
            m_active = 1;
         end
      end else if (!en) begin
         m_active = 0;
         model_err();
      end else if (fr) begin
         ql = '{l};
         qr = '{r};
         model_err();
      end else begin
         ql.push_back(l);
         qr.push_back(r);
         if (ql.size() == W) begin
            exp_l = pack(ql);
            exp_r = pack(qr);
            exp_dv = 1;
            m_active = 0;
         end
      end
      exp_busy = m_active;
   endtask

   task automatic step(input logic en, input logic fr,
                       input logic l, input logic r);
      bus.enable = en;
      bus.Frame  = fr;
      bus.InputL = l;
      bus.InputR = r;
      @(posedge clk);
      if (rst_n) model_step(en, fr, l, r);
      cyc++;
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int nbits);
      for (int i = 0; i < nbits; i++)
         step(1'b1, i == 0, l[W-1-i], r[W-1-i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      chk("dataL", 32'(bus.dataL), 32'(exp_l));
      chk("dataR", 32'(bus.dataR), 32'(exp_r));
      chk("data_valid", 32'(bus.data_valid), 32'(exp_dv));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.data_valid === 1'b1) begin
         dv_seen++;
         last_dv_cyc = cyc;
      end
`ifdef DESER_FRAME_ERR_EN
      chk("frame_err", 32'(bus.frame_err), 32'(exp_fe));
      chk("err_count", 32'(bus.err_count), 32'(exp_ec));
      if (bus.frame_err === 1'b1) last_fe_cyc = cyc;
`endif
   end

   initial begin
      int c0, d0;
      logic [W-1:0] rl, rr;
      bus.enable = 1'b0;
      bus.Frame  = 1'b0;
      bus.InputL = 1'b0;
      bus.InputR = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      idle(3);

      // single word
      c0 = cyc;
      d0 = dv_seen;
      send_bits(16'hA5C3, 16'h0001, W);
      chk("single_dv_now", 32'(bus.data_valid), 32'd1);
      chk("single_L", 32'(bus.dataL), 32'hA5C3);
      chk("single_R", 32'(bus.dataR), 32'h0001);
      chk("model_pin_L", 32'(exp_l), 32'hA5C3);
      idle(2);
      chk("single_dv_cycle", 32'(last_dv_cyc - c0), 32'd16);
      chk("single_dv_count", 32'(dv_seen - d0), 32'd1);
      chk("single_busy_after", 32'(bus.busy), 32'd0);

      // back-to-back
      d0 = dv_seen;
      send_bits(16'h8000, 16'h7FFF, W);
      chk("b2b_L0", 32'(bus.dataL), 32'h8000);
      send_bits(16'h7FFF, 16'h8000, W);
      chk("b2b_L1", 32'(bus.dataL), 32'h7FFF);
      send_bits(16'h0000, 16'hFFFF, W);
      chk("b2b_R2", 32'(bus.dataR), 32'hFFFF);
      idle(1);
      chk("b2b_dv_count", 32'(dv_seen - d0), 32'd3);

      // mid-word Frame
      do_reset();
      idle(2);
      c0 = cyc;
      d0 = dv_seen;
      send_bits(16'h1234, 16'h4321, 7);
      send_bits(16'hBEEF, 16'h0F0F, W);
      idle(1);
      chk("resync_dv_count", 32'(dv_seen - d0), 32'd1);
      chk("resync_dv_cycle", 32'(last_dv_cyc - c0), 32'd23);
      chk("resync_L", 32'(bus.dataL), 32'hBEEF);
      chk("model_pin_R", 32'(exp_r), 32'h0F0F);
`ifdef DESER_FRAME_ERR_EN
      chk("resync_ferr_cycle", 32'(last_fe_cyc - c0), 32'd8);
      chk("resync_err_count", 32'(bus.err_count), 32'd1);
`endif

      // reset mid-word
      send_bits(16'hC0DE, 16'h1111, 9);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_L", 32'(bus.dataL), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b1;
      idle(3);
      chk("rst_no_capture", 32'(bus.busy), 32'd0);
      send_bits(16'h3C5A, 16'h5A3C, W);
      chk("rst_after_L", 32'(bus.dataL), 32'h3C5A);
      idle(1);

      // enable low
      d0 = dv_seen;
      for (int i = 0; i < 20; i++)
         step(1'b0, 1'(i % 2), 1'($urandom), 1'($urandom));
      chk("en_low_busy", 32'(bus.busy), 32'd0);
      send_bits(16'hFFFF, 16'hFFFF, 5);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(20);
      chk("en_drop_dv", 32'(dv_seen - d0), 32'd0);
      chk("en_drop_hold_L", 32'(bus.dataL), 32'h3C5A);
      chk("en_drop_hold_R", 32'(bus.dataR), 32'h5A3C);

      // random words and random framing
      for (int i = 0; i < 40; i++) begin
         rl = W'($urandom);
         rr = W'($urandom);
         send_bits(rl, rr, W);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      for (int i = 0; i < 4000; i++)
         step(1'($urandom_range(0, 19) != 0),
              1'($urandom_range(0, 13) == 0),
              1'($urandom), 1'($urandom));
      idle(2);

      // all-zero stream
      d0 = dv_seen;
      for (int i = 0; i < 800; i++) send_bits('0, '0, W);
      idle(1);
      chk("zeros_dv_count", 32'(dv_seen - d0), 32'd800);
      chk("zeros_L", 32'(bus.dataL), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule
